// File: rtl/vec_seq_pkg.sv
// rtl/vec_seq_pkg.sv - shared opcodes, widths and FSM state type for the issue sequencer
package vec_seq_pkg;

   localparam int OPC_MSB    = 31;
   localparam int OPC_LSB    = 27;
   localparam int LOAD_MSG_W = 64;

   localparam logic [OPC_MSB-OPC_LSB:0] OPC_LOAD  = 5'b00000;
   localparam logic [OPC_MSB-OPC_LSB:0] OPC_STORE = 5'b00001;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE_OP = 3'd1,
      ST_ISSUE_LD = 3'd2,
      ST_ISSUE_ST = 3'd3,
      ST_WAIT_ST  = 3'd4
   } seq_state_t;

   function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [31:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - registered-head FIFO with ready=!full; push is refused while full
module stream_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_val,
   output logic             in_rdy,
   output logic [WIDTH-1:0] out_data,
   output logic             out_empty,
   input  logic             pop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push;
   logic             do_pop;

   assign in_rdy    = (count != CW'(DEPTH));
   assign out_empty = (count == '0);
   assign push      = in_val && in_rdy;
   assign do_pop    = pop && !out_empty;
   assign out_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vec_issue_sequencer.sv
// rtl/vec_issue_sequencer.sv - in-order instruction issue with load pairing and store gating
module vec_issue_sequencer
   import vec_seq_pkg::*;
#(
   parameter int IQ_DEPTH      = 4,
   parameter int LQ_DEPTH      = 4,
   parameter int STORE_TIMEOUT = 1024
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [31:0]           instr_in_msg,
   input  logic                  instr_in_val,
   output logic                  instr_in_rdy,
   input  logic [LOAD_MSG_W-1:0] load_in_msg,
   input  logic                  load_in_val,
   output logic                  load_in_rdy,
   output logic [31:0]           core_instr_msg,
   output logic                  core_instr_val,
   input  logic                  core_instr_rdy,
   output logic [LOAD_MSG_W-1:0] core_load_msg,
   output logic                  core_load_val,
   input  logic                  core_load_rdy,
   input  logic [31:0]           core_store_msg,
   input  logic                  core_store_val,
   output logic                  core_store_rdy,
   output logic [31:0]           store_out_msg,
   output logic                  store_out_val,
   input  logic                  store_out_rdy,
   output logic                  busy,
   output logic [15:0]           issued_cnt,
   output logic                  store_timeout
);

   localparam int TW = (STORE_TIMEOUT > 1) ? $clog2(STORE_TIMEOUT) : 1;

   seq_state_t      state;
   seq_state_t      state_nxt;
   logic            i_done;
   logic            l_done;
   logic [TW-1:0]   timer;

   logic [31:0]           iq_data;
   logic                  iq_empty;
   logic                  iq_pop;
   logic [LOAD_MSG_W-1:0] lq_data;
   logic                  lq_empty;
   logic                  lq_pop;

   logic [4:0] head_opc;
   logic       i_fire;
   logic       l_fire;
   logic       ld_complete;
   logic       in_wait;
   logic       st_fire;

   stream_fifo #(.WIDTH(32), .DEPTH(IQ_DEPTH)) u_instr_fifo (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .in_data   (instr_in_msg),
      .in_val    (instr_in_val),
      .in_rdy    (instr_in_rdy),
      .out_data  (iq_data),
      .out_empty (iq_empty),
      .pop       (iq_pop)
   );

   stream_fifo #(.WIDTH(LOAD_MSG_W), .DEPTH(LQ_DEPTH)) u_load_fifo (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .in_data   (load_in_msg),
      .in_val    (load_in_val),
      .in_rdy    (load_in_rdy),
      .out_data  (lq_data),
      .out_empty (lq_empty),
      .pop       (lq_pop)
   );

   // Core-side outputs come only from state and FIFO heads, never from upstream val.
   assign head_opc       = opcode_of(iq_data);
   assign core_instr_msg = iq_data;
   assign core_load_msg  = lq_data;
   assign core_instr_val = (state == ST_ISSUE_OP) || (state == ST_ISSUE_ST) ||
                           ((state == ST_ISSUE_LD) && !i_done);
   assign core_load_val  = (state == ST_ISSUE_LD) && !l_done;

   assign i_fire      = core_instr_val && core_instr_rdy;
   assign l_fire      = core_load_val && core_load_rdy;
   assign ld_complete = (state == ST_ISSUE_LD) && (i_done || i_fire) && (l_done || l_fire);

   assign iq_pop = (((state == ST_ISSUE_OP) || (state == ST_ISSUE_ST)) && i_fire) || ld_complete;
   assign lq_pop = ld_complete;

   assign in_wait        = (state == ST_WAIT_ST);
   assign store_out_msg  = core_store_msg;
   assign store_out_val  = in_wait && core_store_val;
   assign core_store_rdy = in_wait && store_out_rdy;
   assign st_fire        = store_out_val && store_out_rdy;

   assign busy = (state != ST_IDLE) || !iq_empty;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (!iq_empty) begin
               if (head_opc == OPC_LOAD) begin
                  if (!lq_empty) state_nxt = ST_ISSUE_LD;
               end else if (head_opc == OPC_STORE) begin
                  state_nxt = ST_ISSUE_ST;
               end else begin
                  state_nxt = ST_ISSUE_OP;
               end
            end
         end
         ST_ISSUE_OP: if (i_fire) state_nxt = ST_IDLE;
         ST_ISSUE_LD: if (ld_complete) state_nxt = ST_IDLE;
         ST_ISSUE_ST: if (i_fire) state_nxt = ST_WAIT_ST;
         ST_WAIT_ST:  if (st_fire || (timer == '0)) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state         <= ST_IDLE;
         i_done        <= 1'b0;
         l_done        <= 1'b0;
         timer         <= '0;
         issued_cnt    <= '0;
         store_timeout <= 1'b0;
      end else begin
         state <= state_nxt;

         if (ld_complete) begin
            i_done <= 1'b0;
            l_done <= 1'b0;
         end else if (state == ST_ISSUE_LD) begin
            if (i_fire) i_done <= 1'b1;
            if (l_fire) l_done <= 1'b1;
         end

         // A store handshake on the expiry cycle wins over the timeout.
         if ((state == ST_ISSUE_ST) && i_fire) begin
            timer <= TW'(STORE_TIMEOUT - 1);
         end else if (in_wait && !st_fire && (timer != '0)) begin
            timer <= timer - TW'(1);
         end

         if (in_wait && !st_fire && (timer == '0)) store_timeout <= 1'b1;

         if (iq_pop) issued_cnt <= issued_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_vec_issue_sequencer.sv
// tb/tb_vec_issue_sequencer.sv - scoreboard bench for vec_issue_sequencer
module tb_vec_issue_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr_in_msg = '0;
   logic        instr_in_val = 1'b0;
   logic        instr_in_rdy;
   logic [63:0] load_in_msg = '0;
   logic        load_in_val = 1'b0;
   logic        load_in_rdy;
   logic [31:0] core_instr_msg;
   logic        core_instr_val;
   logic        core_instr_rdy = 1'b0;
   logic [63:0] core_load_msg;
   logic        core_load_val;
   logic        core_load_rdy = 1'b0;
   logic [31:0] core_store_msg = '0;
   logic        core_store_val = 1'b0;
   logic        core_store_rdy;
   logic [31:0] store_out_msg;
   logic        store_out_val;
   logic        store_out_rdy = 1'b0;
   logic        busy;
   logic [15:0] issued_cnt;
   logic        store_timeout;

   int checks = 0;
   int failures = 0;

   logic [31:0] exp_instr [$];
   logic [63:0] exp_load  [$];
   logic [31:0] exp_store [$];

   vec_issue_sequencer #(.IQ_DEPTH(4), .LQ_DEPTH(4), .STORE_TIMEOUT(8)) dut (
      .wb_clk_i       (clk),
      .wb_rst_i       (rst),
      .instr_in_msg   (instr_in_msg),
      .instr_in_val   (instr_in_val),
      .instr_in_rdy   (instr_in_rdy),
      .load_in_msg    (load_in_msg),
      .load_in_val    (load_in_val),
      .load_in_rdy    (load_in_rdy),
      .core_instr_msg (core_instr_msg),
      .core_instr_val (core_instr_val),
      .core_instr_rdy (core_instr_rdy),
      .core_load_msg  (core_load_msg),
      .core_load_val  (core_load_val),
      .core_load_rdy  (core_load_rdy),
      .core_store_msg (core_store_msg),
      .core_store_val (core_store_val),
      .core_store_rdy (core_store_rdy),
      .store_out_msg  (store_out_msg),
      .store_out_val  (store_out_val),
      .store_out_rdy  (store_out_rdy),
      .busy           (busy),
      .issued_cnt     (issued_cnt),
      .store_timeout  (store_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      checks++;
      failures++;
      $display("FAIL %s unexpected handshake actual=%h expected=none", name, act);
   endtask

   // Monitor: samples handshakes on the falling edge and pops the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (core_instr_val && core_instr_rdy) begin
            if (exp_instr.size() == 0) unexpected("core_instr", {32'h0, core_instr_msg});
            else chk("core_instr", {32'h0, core_instr_msg}, {32'h0, exp_instr.pop_front()});
         end
         if (core_load_val && core_load_rdy) begin
            if (exp_load.size() == 0) unexpected("core_load", core_load_msg);
            else chk("core_load", core_load_msg, exp_load.pop_front());
         end
         if (store_out_val && store_out_rdy) begin
            if (exp_store.size() == 0) unexpected("store_out", {32'h0, store_out_msg});
            else chk("store_out", {32'h0, store_out_msg}, {32'h0, exp_store.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      instr_in_val = 1'b0;
      load_in_val = 1'b0;
      core_instr_rdy = 1'b0;
      core_load_rdy = 1'b0;
      core_store_val = 1'b0;
      store_out_rdy = 1'b0;
      exp_instr.delete();
      exp_load.delete();
      exp_store.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
   endtask

   task automatic push_instr(input logic [31:0] m);
      logic ok;
      ok = 1'b0;
      instr_in_msg = m;
      instr_in_val = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (instr_in_rdy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) tick();
      else unexpected("push_instr_timeout", {32'h0, m});
      instr_in_val = 1'b0;
   endtask

   task automatic push_load(input logic [63:0] m);
      logic ok;
      ok = 1'b0;
      load_in_msg = m;
      load_in_val = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (load_in_rdy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) tick();
      else unexpected("push_load_timeout", m);
      load_in_val = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_instr_val", {63'h0, core_instr_val}, 64'd0);
      chk("rst_load_val", {63'h0, core_load_val}, 64'd0);
      chk("rst_store_out_val", {63'h0, store_out_val}, 64'd0);
      chk("rst_core_store_rdy", {63'h0, core_store_rdy}, 64'd0);
      chk("rst_busy", {63'h0, busy}, 64'd0);
      chk("rst_in_rdys", {62'h0, instr_in_rdy, load_in_rdy}, 64'd3);
      chk("rst_issued_cnt", {48'h0, issued_cnt}, 64'd0);
      chk("rst_store_timeout", {63'h0, store_timeout}, 64'd0);

      // Single OP: val appears two cycles after the upstream handshake.
      core_instr_rdy = 1'b1;
      exp_instr.push_back(32'h40000001);
      push_instr(32'h40000001);
      chk("t1_val_at_n1", {63'h0, core_instr_val}, 64'd0);
      tick();
      chk("t1_val_at_n2", {63'h0, core_instr_val}, 64'd1);
      tick();
      chk("t1_issued_cnt", {48'h0, issued_cnt}, 64'd1);
      chk("t1_busy", {63'h0, busy}, 64'd0);

      // LOAD paired with its data beat; load side stalls 3 cycles.
      do_reset();
      core_instr_rdy = 1'b1;
      exp_instr.push_back(32'h00000000);
      exp_load.push_back({32'h3, 32'hDEADBEEF});
      push_instr(32'h00000000);
      push_load({32'h3, 32'hDEADBEEF});
      for (int i = 0; i < 10 && !core_load_val; i++) tick();
      chk("t2_enter_ld", {63'h0, core_load_val}, 64'd1);
      repeat (3) tick();
      chk("t2_instr_once", {63'h0, core_instr_val}, 64'd0);
      chk("t2_load_held", {63'h0, core_load_val}, 64'd1);
      chk("t2_cnt_before", {48'h0, issued_cnt}, 64'd0);
      core_load_rdy = 1'b1;
      tick();
      chk("t2_cnt_after", {48'h0, issued_cnt}, 64'd1);
      chk("t2_load_val_off", {63'h0, core_load_val}, 64'd0);
      tick();
      chk("t2_busy", {63'h0, busy}, 64'd0);

      // STORE: store path gated until WAIT_ST, then one beat passes.
      do_reset();
      core_instr_rdy = 1'b1;
      exp_instr.push_back(32'h08000000);
      push_instr(32'h08000000);
      core_store_msg = 32'hCAFEF00D;
      core_store_val = 1'b1;
      store_out_rdy = 1'b1;
      chk("t3_idle_gate", {62'h0, store_out_val, core_store_rdy}, 64'd0);
      tick();
      chk("t3_issue_gate", {62'h0, store_out_val, core_store_rdy}, 64'd0);
      core_store_val = 1'b0;
      tick();
      chk("t3_wait_rdy", {63'h0, core_store_rdy}, 64'd1);
      repeat (4) tick();
      exp_store.push_back(32'hCAFEF00D);
      core_store_val = 1'b1;
      tick();
      core_store_val = 1'b0;
      chk("t3_busy", {63'h0, busy}, 64'd0);
      chk("t3_store_timeout", {63'h0, store_timeout}, 64'd0);
      chk("t3_issued_cnt", {48'h0, issued_cnt}, 64'd1);

      // STORE timeout after 8 WAIT_ST cycles, then queued OP issues.
      do_reset();
      core_instr_rdy = 1'b1;
      store_out_rdy = 1'b1;
      exp_instr.push_back(32'h08000001);
      exp_instr.push_back(32'h40000002);
      push_instr(32'h08000001);
      push_instr(32'h40000002);
      tick();
      chk("t4_wait_entry", {62'h0, core_store_rdy, store_timeout}, 64'd2);
      repeat (7) tick();
      chk("t4_wait_last", {62'h0, core_store_rdy, store_timeout}, 64'd2);
      tick();
      chk("t4_timed_out", {62'h0, core_store_rdy, store_timeout}, 64'd1);
      repeat (4) tick();
      chk("t4_issued_cnt", {48'h0, issued_cnt}, 64'd2);
      chk("t4_sticky", {63'h0, store_timeout}, 64'd1);
      chk("t4_busy", {63'h0, busy}, 64'd0);

      // Back-pressure: 4 OPs fill the FIFO, 5th held until the core drains.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         exp_instr.push_back(32'h40000010 + 32'(i));
         push_instr(32'h40000010 + 32'(i));
      end
      chk("t5_full", {63'h0, instr_in_rdy}, 64'd0);
      exp_instr.push_back(32'h40000014);
      instr_in_msg = 32'h40000014;
      instr_in_val = 1'b1;
      repeat (2) tick();
      chk("t5_still_full", {63'h0, instr_in_rdy}, 64'd0);
      chk("t5_cnt_stalled", {48'h0, issued_cnt}, 64'd0);
      core_instr_rdy = 1'b1;
      push_instr(32'h40000014);
      for (int i = 0; i < 40 && issued_cnt != 16'd5; i++) tick();
      chk("t5_issued_cnt", {48'h0, issued_cnt}, 64'd5);
      tick();
      chk("t5_busy", {63'h0, busy}, 64'd0);

      // Asynchronous reset during ISSUE_LD drops everything.
      do_reset();
      push_instr(32'h00000000);
      push_instr(32'h00000000);
      push_load({32'h1, 32'h11111111});
      push_load({32'h2, 32'h22222222});
      for (int i = 0; i < 10 && !core_load_val; i++) tick();
      chk("t6_in_ld", {62'h0, core_instr_val, core_load_val}, 64'd3);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_vals", {62'h0, core_instr_val, core_load_val}, 64'd0);
      chk("t6_async_busy", {63'h0, busy}, 64'd0);
      chk("t6_async_cnt", {48'h0, issued_cnt}, 64'd0);
      chk("t6_async_rdys", {62'h0, instr_in_rdy, load_in_rdy}, 64'd3);
      core_instr_rdy = 1'b1;
      core_load_rdy = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) tick();
      chk("t6_no_replay", {62'h0, core_instr_val, core_load_val}, 64'd0);
      chk("t6_cnt_after", {48'h0, issued_cnt}, 64'd0);

      chk("drain_instr", 64'(exp_instr.size()), 64'd0);
      chk("drain_load", 64'(exp_load.size()), 64'd0);
      chk("drain_store", 64'(exp_store.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/vec_issue_sequencer.md
Name: vec_issue_sequencer

Overview:
Sits between the Wishbone-to-stream converter and the vector core. It buffers the instruction stream and the load-data stream, and issues instructions to the core strictly in order. A load instruction is paired with its load-data beat. A store instruction gates the store return path until exactly one store beat reaches the converter, or until a timeout fires. Status outputs report busy, the issue count and a sticky store-timeout flag.

Parameters:
IQ_DEPTH, 4, instruction FIFO depth; power of 2, at least 2
LQ_DEPTH, 4, load-data FIFO depth; power of 2, at least 2
STORE_TIMEOUT, 1024, cycles allowed in WAIT_ST before the store is abandoned

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous, active-high reset
instr_in_msg  in  32  instruction from converter
instr_in_val  in  1  instruction valid
instr_in_rdy  out  1  instruction FIFO not full
load_in_msg  in  64  load beat {word_index[31:0], data[31:0]} from converter
load_in_val  in  1  load beat valid
load_in_rdy  out  1  load FIFO not full
core_instr_msg  out  32  instruction to core
core_instr_val  out  1  instruction valid
core_instr_rdy  in  1  core accepts instruction
core_load_msg  out  64  load beat to core
core_load_val  out  1  load beat valid
core_load_rdy  in  1  core accepts load beat
core_store_msg  in  32  store data from core
core_store_val  in  1  store data valid
core_store_rdy  out  1  store data accepted
store_out_msg  out  32  store data to converter
store_out_val  out  1  store data valid
store_out_rdy  in  1  converter accepts store data
busy  out  1  state!=IDLE or instruction FIFO non-empty
issued_cnt  out  16  completed issues; wraps 0xFFFF->0
store_timeout  out  1  sticky; set when a store times out

Behaviour:
- Reset: the single clock is wb_clk_i; wb_rst_i is an asynchronous, active-high reset.
  - On reset: both FIFOs empty, state=IDLE, done flags=0, timer=0, issued_cnt=0, store_timeout=0.
  - Resulting outputs: all *_val=0, core_store_rdy=0, busy=0, instr_in_rdy=load_in_rdy=1.
  - Reset mid-operation drops every queued or in-flight beat; nothing is replayed.
- FIFOs:
  - rdy = !full. Enqueue occurs on val&&rdy.
  - A push is refused while full, even if a pop happens in the same cycle.
  - A simultaneous push and pop when not full leaves the count unchanged.
  - Pointers wrap modulo depth; count width is clog2(depth)+1.
- Opcode: instruction bits [31:27]. 5'b00000=LOAD, 5'b00001=STORE, anything else=OP.
- FSM states: IDLE, ISSUE_OP, ISSUE_LD, ISSUE_ST, WAIT_ST.
  - IDLE, instruction FIFO empty: stay in IDLE.
  - IDLE, head=LOAD: go to ISSUE_LD only if the load FIFO is non-empty; otherwise stall in IDLE with no timeout.
  - IDLE, head=STORE: go to ISSUE_ST. Head=OP: go to ISSUE_OP.
  - ISSUE_OP: core_instr_val=1, msg=head. On core_instr_rdy: pop the instruction FIFO, issued_cnt++, go to IDLE.
  - ISSUE_LD: core_instr_val=!i_done, core_load_val=!l_done, driven from both FIFO heads.
    - Each handshake sets its done flag.
    - Once both are complete (same cycle or different cycles): pop both FIFOs, clear the flags, issued_cnt++, go to IDLE.
  - ISSUE_ST: core_instr_val=1. On rdy: pop, issued_cnt++, timer=STORE_TIMEOUT-1, go to WAIT_ST.
  - WAIT_ST:
    - Pass-through: store_out_msg=core_store_msg, store_out_val=core_store_val, core_store_rdy=store_out_rdy.
    - On store_out_val&&store_out_rdy: go to IDLE.
    - Otherwise, if timer==0: set store_timeout, go to IDLE. Else timer--.
    - If a handshake and timer==0 happen in the same cycle, the handshake wins and no timeout is recorded.
- Outside WAIT_ST: core_store_rdy=0 and store_out_val=0; core store beats are held off.
- Load beats with no matching LOAD instruction stay queued, and the load FIFO back-pressures when full.
- Latency: an upstream instruction handshake in cycle N gives core_instr_val=1 no earlier than cycle N+2. Throughput is one OP per 2 cycles.
- No combinational path exists from any upstream val to any core-side output.

Decomposition:
- Package vec_seq_pkg holds:
  - OPC_MSB=31, OPC_LSB=27
  - OPC_LOAD=5'b00000, OPC_STORE=5'b00001
  - the FSM state enum
  - LOAD_MSG_W=64
- One sub-module, stream_fifo #(WIDTH, DEPTH), instantiated twice (instruction FIFO and load FIFO).

Test Plan:
1. Push OP 0x40000001 with core_instr_rdy=1 -> core_instr_val high 2 cycles after the push, msg=0x40000001, issued_cnt=1, busy returns to 0.
2. Push LOAD 0x00000000 then load beat {0x3,0xDEADBEEF}. Hold core_load_rdy=0 for 3 cycles while core_instr_rdy=1 -> instruction accepted once, load beat presented until rdy, both FIFOs pop together, issued_cnt=1.
3. Push STORE 0x08000000, core returns 0xCAFEF00D with store_out_rdy=1 after 5 cycles -> store_out_msg=0xCAFEF00D; core_store_rdy was 0 before WAIT_ST; state=IDLE; store_timeout=0.
4. STORE_TIMEOUT=8, push STORE, core never sends -> after 8 cycles in WAIT_ST store_timeout=1 (sticky), the next queued OP then issues.
5. core_instr_rdy=0, push 5 OPs -> instr_in_rdy=0 after 4 accepted, 5th held. Release rdy -> all 5 issue in order, issued_cnt=5.
6. Assert wb_rst_i mid-ISSUE_LD with 2 loads queued -> all vals drop immediately (asynchronously), FIFOs empty, issued_cnt=0, no issue after release.
